// File: rtl/memory_read_client.sv
// Read-burst requester for one arbiter slot; buffers returned words in a
// local FIFO and streams them out, with credits bounding reads in flight.
// Ports: clk/reset_n; start/base_address/length/busy/done/error control;
// req_* to the arbiter, rsp_* from it; pix_* valid/ready output stream.
module memory_read_client #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 16,
  parameter int LENGTH_WIDTH  = 16,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [LENGTH_WIDTH-1:0]  length,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     req_wr,
  output logic [DATA_WIDTH-1:0]    req_data,
  output logic                     req_valid,
  input  logic                     req_full,
  input  logic [DATA_WIDTH-1:0]    rsp_data,
  input  logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready
);

  localparam int PW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state_q;
  logic [LENGTH_WIDTH-1:0]  len_q;
  logic [LENGTH_WIDTH-1:0]  issued_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [CW-1:0]            outst_q;
  logic [CW-1:0]            count_q;
  logic [PW-1:0]            wptr_q;
  logic [PW-1:0]            rptr_q;
  logic                     done_q;
  logic                     error_q;
  logic [DATA_WIDTH-1:0]    mem_q [RX_FIFO_DEPTH];

  logic [CW:0]           used;
  logic                  has_credit;
  logic                  take;
  logic                  push;
  logic                  stray;
  logic                  pop;
  logic                  last;
  logic [CW-1:0]         outst_d;
  logic [CW-1:0]         count_d;
  logic [LENGTH_WIDTH-1:0] issued_d;

  // Slots already claimed: reads in flight plus words waiting in the FIFO.
  assign used       = {1'b0, outst_q} + {1'b0, count_q};
  assign has_credit = used < (CW+1)'(RX_FIFO_DEPTH);
  assign take       = (state_q == ISSUE) & ~req_full & has_credit;
  assign push       = rsp_valid & (outst_q != '0);
  assign stray      = rsp_valid & (outst_q == '0);
  assign pop        = (count_q != '0) & pix_ready;
  assign issued_d   = issued_q + LENGTH_WIDTH'(1);
  assign last       = take & (issued_d == len_q);

  always_comb begin
    outst_d = outst_q;
    unique case ({take, push})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      addr_q   <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      outst_q <= outst_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              len_q    <= length;
              issued_q <= '0;
              addr_q   <= base_address;
              error_q  <= 1'b0;
              state_q  <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (take) begin
            issued_q <= issued_d;
            addr_q   <= addr_q + ADDRESS_WIDTH'(1);
            if (last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (outst_q == '0 && count_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A stray response wins over a same-cycle start clearing the flag.
      if (stray) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rsp_data;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign req_address = addr_q;
  assign req_wr      = 1'b0;
  assign req_data    = '0;
  assign req_valid   = take;
  assign pix_valid   = (count_q != '0);
  assign pix_data    = mem_q[rptr_q];

endmodule

// File: tb/tb_memory_read_client.sv
// Bench for memory_read_client: 2-cycle arbiter model, table bursts,
// randomized bursts, and hand-written idle/zero-length/reset sequences.
module tb_memory_read_client;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [24:0] base_address;
  logic [15:0] length;
  logic        busy, done, error;
  logic [24:0] req_address;
  logic        req_wr;
  logic [15:0] req_data;
  logic        req_valid;
  logic        req_full;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  int checks = 0;
  int errors = 0;

  logic        p_v [2];
  logic [15:0] p_d [2];

  memory_read_client dut (
    .clk(clk), .reset_n(reset_n),
    .start(start), .base_address(base_address),
    .length(length), .busy(busy), .done(done),
    .error(error), .req_address(req_address),
    .req_wr(req_wr), .req_data(req_data),
    .req_valid(req_valid), .req_full(req_full),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] base;
    int          len;
    int          full_after;
    int          full_cycles;
    int          ready_delay;
    logic [24:0] exp_last;
    int          exp_max;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [24:0] a);
    return a[15:0] ^ {7'd0, a[24:16]} ^ 16'hC3A5;
  endfunction

  task automatic run_burst(
    input  logic [24:0] base, input int len,
    input  int full_after, input int full_cycles,
    input  int ready_delay, input bit rnd,
    input  int abort_after,
    output int nreq, output int nwords,
    output int maxfl, output int ndone,
    output logic [24:0] last_a);
    int issued, popped, delivered, stall, cyc;
    bit fin, exp_rv;
    issued = 0; popped = 0; delivered = 0;
    stall = 0; cyc = 0; fin = 0;
    maxfl = 0; ndone = 0; last_a = '0;
    @(negedge clk);
    start = 1'b1;
    base_address = base;
    length = 16'(len);
    req_full = 1'b0;
    pix_ready = 1'b0;
    rsp_valid = 1'b0;
    @(posedge clk);
    while (!fin) begin
      @(negedge clk);
      start = 1'b0;
      req_full = rnd ? ($urandom_range(3) == 0) : (stall > 0);
      if (stall > 0) stall--;
      pix_ready = rnd ? ($urandom_range(2) != 0)
                      : (cyc >= ready_delay);
      rsp_valid = p_v[1];
      rsp_data = p_d[1];
      #1;
      exp_rv = (issued < len) && !req_full &&
               (issued - popped < 16);
      chk(req_valid == exp_rv, "req_valid", req_valid, exp_rv);
      chk(pix_valid == (delivered > popped), "pix_valid",
          pix_valid, delivered > popped);
      chk(error == 1'b0, "error_in_burst", error, 0);
      chk(busy == !done, "busy", busy, !done);
      if (req_valid) begin
        chk(req_address == 25'(base + issued), "req_address",
            req_address, 25'(base + issued));
        last_a = req_address;
        issued++;
        if (issued == full_after) stall = full_cycles;
      end
      if (pix_valid && pix_ready) begin
        chk(pix_data == memf(25'(base + popped)), "pix_data",
            pix_data, memf(25'(base + popped)));
        popped++;
      end
      if (rsp_valid) delivered++;
      if (issued - popped > maxfl) maxfl = issued - popped;
      if (done) begin
        ndone++;
        chk(popped == len, "done_words", popped, len);
        fin = 1;
      end
      p_v[1] = p_v[0];
      p_d[1] = p_d[0];
      p_v[0] = req_valid;
      p_d[0] = memf(req_address);
      cyc++;
      if (abort_after > 0 && cyc >= abort_after) fin = 1;
      if (cyc > 3000) begin
        chk(1'b0, "timeout", cyc, 3000);
        fin = 1;
      end
    end
    nreq = issued;
    nwords = popped;
    if (abort_after == 0) begin
      @(negedge clk);
      #1;
      chk(done == 1'b0, "done_one_cycle", done, 0);
      chk(busy == 1'b0, "busy_after", busy, 0);
    end
  endtask

  initial begin
    int nreq, nw, mf, nd;
    logic [24:0] la;
    logic [24:0] rb;
    int rl;

    vecs[0] = '{25'h100, 4, 0, 0, 0, 25'h103, 0};
    vecs[1] = '{25'h2000, 8, 3, 5, 0, 25'h2007, 0};
    vecs[2] = '{25'h3000, 40, 0, 0, 40, 25'h3027, 16};
    vecs[3] = '{25'h1FFFFFE, 4, 0, 0, 0, 25'h0000001, 0};

    p_v[0] = 0; p_v[1] = 0; p_d[0] = 0; p_d[1] = 0;
    reset_n = 1'b0;
    start = 0; base_address = 0; length = 0;
    req_full = 0; rsp_data = 0; rsp_valid = 0;
    pix_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk(busy == 0, "rst_busy", busy, 0);
    chk(done == 0, "rst_done", done, 0);
    chk(error == 0, "rst_error", error, 0);
    chk(req_valid == 0, "rst_req_valid", req_valid, 0);
    chk(pix_valid == 0, "rst_pix_valid", pix_valid, 0);
    chk(req_address == 0, "rst_req_address", req_address, 0);
    chk(req_wr == 0, "req_wr", req_wr, 0);
    chk(req_data == 0, "req_data", req_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_burst(vecs[i].base, vecs[i].len,
                vecs[i].full_after, vecs[i].full_cycles,
                vecs[i].ready_delay, 1'b0, 0,
                nreq, nw, mf, nd, la);
      chk(nreq == vecs[i].len, "t_nreq", nreq, vecs[i].len);
      chk(nw == vecs[i].len, "t_nwords", nw, vecs[i].len);
      chk(nd == 1, "t_ndone", nd, 1);
      chk(la == vecs[i].exp_last, "t_last_addr", la,
          vecs[i].exp_last);
      if (vecs[i].exp_max > 0)
        chk(mf == vecs[i].exp_max, "t_max_inflight", mf,
            vecs[i].exp_max);
      else
        chk(mf <= 16, "t_max_inflight", mf, 16);
    end

    // zero-length start
    @(negedge clk);
    start = 1'b1;
    length = 16'd0;
    base_address = 25'h555;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk(done == 1, "zl_done", done, 1);
    chk(busy == 0, "zl_busy", busy, 0);
    chk(req_valid == 0, "zl_req_valid", req_valid, 0);
    @(negedge clk);
    #1;
    chk(done == 0, "zl_done_drop", done, 0);
    chk(busy == 0, "zl_busy2", busy, 0);
    chk(req_valid == 0, "zl_req_valid2", req_valid, 0);

    // stray response while idle
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data = 16'hBEEF;
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk(error == 1, "idle_error", error, 1);
    chk(pix_valid == 0, "idle_pix_valid", pix_valid, 0);
    @(negedge clk);
    #1;
    chk(error == 1, "error_sticky", error, 1);

    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      rb = 25'($urandom);
      if (r == 0) rb = 25'h1FFFFF0;
      rl = $urandom_range(48, 1);
      run_burst(rb, rl, 0, 0, 0, 1'b1, 0,
                nreq, nw, mf, nd, la);
      chk(nreq == rl, "r_nreq", nreq, rl);
      chk(nw == rl, "r_nwords", nw, rl);
      chk(nd == 1, "r_ndone", nd, 1);
      chk(mf <= 16, "r_max_inflight", mf, 16);
      chk(la == 25'(rb + rl - 1), "r_last_addr", la,
          25'(rb + rl - 1));
    end

    // reset mid-burst
    run_burst(25'h4000, 20, 0, 0, 1000, 1'b0, 6,
              nreq, nw, mf, nd, la);
    @(posedge clk);
    #2;
    chk(busy == 1, "pre_rst_busy", busy, 1);
    chk(req_valid == 1, "pre_rst_req_valid", req_valid, 1);
    chk(pix_valid == 1, "pre_rst_pix_valid", pix_valid, 1);
    reset_n = 1'b0;
    rsp_valid = 1'b0;
    #1;
    chk(busy == 0, "mid_rst_busy", busy, 0);
    chk(req_valid == 0, "mid_rst_req_valid", req_valid, 0);
    chk(pix_valid == 0, "mid_rst_pix_valid", pix_valid, 0);
    chk(error == 0, "mid_rst_error", error, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data = 16'h1234;
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk(error == 1, "late_rsp_error", error, 1);
    chk(pix_valid == 0, "late_rsp_pix_valid", pix_valid, 0);
    p_v[0] = 0; p_v[1] = 0;

    // burst after reset clears error and works
    run_burst(25'h50, 5, 0, 0, 0, 1'b0, 0,
              nreq, nw, mf, nd, la);
    chk(nw == 5, "post_rst_nwords", nw, 5);
    chk(nd == 1, "post_rst_ndone", nd, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
